// File: rtl/reorder_buffer_pkg.sv
// reorder_buffer_pkg: shared widths and the per-entry record of the reorder buffer
package reorder_buffer_pkg;
   localparam int ARCH_REG_W = 5;
   localparam int PHYS_W     = 6;
   localparam int ROB_DEPTH  = 16;
   localparam int ROB_TAG_W  = $clog2(ROB_DEPTH);
   typedef struct packed {
      logic                  valid;
      logic                  done;
      logic [ARCH_REG_W-1:0] rd;
      logic [PHYS_W-1:0]     old_phys;
   } rob_entry_t;
endpackage

// File: rtl/reorder_buffer_if.sv
// reorder_buffer_if: allocate / complete / flush / retire signals of the reorder buffer
interface reorder_buffer_if #(
   parameter int TAG_W  = reorder_buffer_pkg::ROB_TAG_W,
   parameter int PHYS_W = reorder_buffer_pkg::PHYS_W
);
   logic                                      alloc_valid;
   logic [reorder_buffer_pkg::ARCH_REG_W-1:0] alloc_rd;
   logic [PHYS_W-1:0]                         alloc_old_phys_rd;
   logic                                      alloc_ready;
   logic [TAG_W-1:0]                          alloc_tag;
   logic                                      complete_valid;
   logic [TAG_W-1:0]                          complete_tag;
   logic                                      flush;
   logic                                      commit_valid;
   logic                                      retire_valid;
   logic [PHYS_W-1:0]                         retire_phys_reg;
   logic [TAG_W:0]                            count;
   modport master (
      output alloc_valid, alloc_rd, alloc_old_phys_rd, complete_valid, complete_tag, flush,
      input  alloc_ready, alloc_tag, commit_valid, retire_valid, retire_phys_reg, count
   );
   modport slave (
      input  alloc_valid, alloc_rd, alloc_old_phys_rd, complete_valid, complete_tag, flush,
      output alloc_ready, alloc_tag, commit_valid, retire_valid, retire_phys_reg, count
   );
endinterface

// File: rtl/reorder_buffer_rob_ptr.sv
// rob_ptr: wrap-bit pointer counter with increment and clear (clear wins)
module rob_ptr #(
   parameter int W = 5
)(
   input  logic         clk,
   input  logic         reset,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] ptr
);
   // pointer advances by one per accepted event; MSB toggles on wrap
   always_ff @(posedge clk or posedge reset)
      if (reset)    ptr <= '0;
      else if (clr) ptr <= '0;
      else if (inc) ptr <= ptr + 1'b1;
endmodule

// File: rtl/reorder_buffer.sv
// reorder_buffer: in-order retirement of out-of-order completed instructions
module reorder_buffer #(
   parameter int DEPTH  = 16,
   parameter int TAG_W  = 4,
   parameter int PHYS_W = 6
)(
   input  logic             clk,
   input  logic             reset,
   reorder_buffer_if.slave  bus
);
   import reorder_buffer_pkg::*;
   logic [TAG_W:0]    head, tail;
   logic [TAG_W-1:0]  head_idx, tail_idx;
   rob_entry_t        rob [DEPTH];
   rob_entry_t        head_e;
   logic              full, do_alloc, do_retire, frees_reg;
   logic              commit_q, retire_q;
   logic [PHYS_W-1:0] phys_q;

   rob_ptr #(.W(TAG_W+1)) u_head (.clk(clk), .reset(reset), .clr(bus.flush), .inc(do_retire), .ptr(head));
   rob_ptr #(.W(TAG_W+1)) u_tail (.clk(clk), .reset(reset), .clr(bus.flush), .inc(do_alloc),  .ptr(tail));

   // full when the pointers differ only in the wrap bit; flush suppresses alloc and retire
   always_comb begin
      head_idx  = head[TAG_W-1:0];
      tail_idx  = tail[TAG_W-1:0];
      head_e    = rob[head_idx];
      full      = (head ^ tail) == {1'b1, {TAG_W{1'b0}}};
      do_alloc  = bus.alloc_valid && !full && !bus.flush;
      do_retire = head_e.valid && head_e.done && !bus.flush;
      frees_reg = do_retire && head_e.rd != '0;
   end

   assign bus.alloc_ready     = !full;
   assign bus.alloc_tag       = tail_idx;
   assign bus.count           = tail - head;
   assign bus.commit_valid    = commit_q;
   assign bus.retire_valid    = retire_q;
   assign bus.retire_phys_reg = phys_q;

   // entry table: completion only marks entries valid before the edge; retire overrides it on the head
   always_ff @(posedge clk or posedge reset)
      if (reset || bus.flush) begin
         for (int i = 0; i < DEPTH; i++) rob[i] <= '0;
      end else begin
         if (bus.complete_valid && rob[bus.complete_tag].valid) rob[bus.complete_tag].done <= 1'b1;
         if (do_retire) rob[head_idx] <= '0;
         if (do_alloc)  rob[tail_idx] <= '{valid: 1'b1, done: 1'b0, rd: bus.alloc_rd, old_phys: bus.alloc_old_phys_rd};
      end

   // one-cycle retire report in the cycle after the retiring edge; x0 frees nothing
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         commit_q <= 1'b0;
         retire_q <= 1'b0;
         phys_q   <= '0;
      end else begin
         commit_q <= do_retire;
         retire_q <= frees_reg;
         phys_q   <= frees_reg ? head_e.old_phys : '0;
      end
endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: vector table plus queue model and retire scoreboard for reorder_buffer
module tb_reorder_buffer;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   reorder_buffer_if bus ();
   reorder_buffer dut (.clk(clk), .reset(rst), .bus(bus));

   typedef struct {int tag; logic [4:0] rd; logic [5:0] op; bit done;} ment_t;
   typedef struct {logic [4:0] rd; logic [5:0] op;} exp_t;
   typedef struct {
      logic av; logic [4:0] rd; logic [5:0] op; logic cv; logic [3:0] ct; logic fl;
      int cnt; logic cm; logic rv; logic [5:0] ph;
   } vec_t;

   ment_t mq[$];
   exp_t  exq[$];
   vec_t  tbl[16];
   int    m_tail, checks, failures, n_ret;

   task automatic chk(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(logic av, logic [4:0] rd, logic [5:0] op, logic cv, logic [3:0] ct, logic fl);
      bus.alloc_valid       = av;
      bus.alloc_rd          = rd;
      bus.alloc_old_phys_rd = op;
      bus.complete_valid    = cv;
      bus.complete_tag      = ct;
      bus.flush             = fl;
   endtask

   task automatic model_clear();
      mq.delete();
      exq.delete();
      m_tail = 0;
   endtask

   task automatic tick();
      int pre;
      bit ret, acc;
      exp_t e;
      ret = 0;
      pre = mq.size();
      acc = bus.alloc_valid && pre < 16;
      if (bus.flush) model_clear();
      else begin
         if (pre > 0 && mq[0].done) begin
            ret = 1;
            exq.push_back('{mq[0].rd, mq[0].op});
            void'(mq.pop_front());
            n_ret++;
         end
         if (bus.complete_valid)
            foreach (mq[i]) if (mq[i].tag == int'(bus.complete_tag)) mq[i].done = 1;
         if (acc) begin
            mq.push_back('{m_tail, bus.alloc_rd, bus.alloc_old_phys_rd, 1'b0});
            m_tail = (m_tail + 1) % 16;
         end
      end
      @(posedge clk);
      #1;
      chk("commit_valid", int'(bus.commit_valid), int'(ret));
      if (bus.commit_valid) begin
         if (exq.size() == 0) chk("unexpected_commit", 1, 0);
         else begin
            e = exq.pop_front();
            chk("retire_valid", int'(bus.retire_valid), int'(e.rd != 0));
            chk("retire_phys", int'(bus.retire_phys_reg), e.rd != 0 ? int'(e.op) : 0);
         end
      end
      chk("count", int'(bus.count), mq.size());
      chk("alloc_ready", int'(bus.alloc_ready), int'(mq.size() < 16));
      chk("alloc_tag", int'(bus.alloc_tag), m_tail);
   endtask

   task automatic do_reset();
      drive(0, 0, 0, 0, 0, 0);
      rst = 1'b1;
      #2;
      chk("rst_count", int'(bus.count), 0);
      chk("rst_ready", int'(bus.alloc_ready), 1);
      chk("rst_tag", int'(bus.alloc_tag), 0);
      chk("rst_commit", int'(bus.commit_valid), 0);
      chk("rst_retire", int'(bus.retire_valid), 0);
      chk("rst_phys", int'(bus.retire_phys_reg), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_clear();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1);
   end

   initial begin
      logic       cv;
      logic [3:0] ct;
      int         k;
      checks = 0; failures = 0; n_ret = 0;
      //          av rd op cv ct fl  cnt cm rv ph
      tbl = '{
         '{1, 1, 10, 0, 0, 0,  1, 0, 0,  0},
         '{1, 2, 11, 0, 0, 0,  2, 0, 0,  0},
         '{1, 0, 40, 0, 0, 0,  3, 0, 0,  0},
         '{1, 3, 13, 0, 0, 0,  4, 0, 0,  0},
         '{0, 0,  0, 1, 3, 0,  4, 0, 0,  0},
         '{0, 0,  0, 1, 0, 0,  4, 0, 0,  0},
         '{0, 0,  0, 1, 1, 0,  3, 1, 1, 10},
         '{0, 0,  0, 1, 2, 0,  2, 1, 1, 11},
         '{0, 0,  0, 0, 0, 0,  1, 1, 0,  0},
         '{0, 0,  0, 0, 0, 0,  0, 1, 1, 13},
         '{0, 0,  0, 0, 0, 0,  0, 0, 0,  0},
         '{0, 0,  0, 1, 5, 0,  0, 0, 0,  0},
         '{1, 4, 20, 1, 4, 0,  1, 0, 0,  0},
         '{0, 0,  0, 0, 0, 0,  1, 0, 0,  0},
         '{0, 0,  0, 1, 4, 0,  1, 0, 0,  0},
         '{0, 0,  0, 0, 0, 0,  0, 1, 1, 20}
      };

      do_reset();
      for (int i = 0; i < 16; i++) begin
         drive(tbl[i].av, tbl[i].rd, tbl[i].op, tbl[i].cv, tbl[i].ct, tbl[i].fl);
         tick();
         chk($sformatf("vec%0d_count", i), int'(bus.count), tbl[i].cnt);
         chk($sformatf("vec%0d_commit", i), int'(bus.commit_valid), int'(tbl[i].cm));
         chk($sformatf("vec%0d_retire", i), int'(bus.retire_valid), int'(tbl[i].rv));
         chk($sformatf("vec%0d_phys", i), int'(bus.retire_phys_reg), int'(tbl[i].ph));
      end

      do_reset();
      for (int i = 0; i < 16; i++) begin
         drive(1, 5'(i + 1), 6'(i + 30), 0, 0, 0);
         tick();
      end
      chk("full_ready", int'(bus.alloc_ready), 0);
      chk("full_count", int'(bus.count), 16);
      drive(1, 9, 9, 0, 0, 0);
      tick();
      chk("alloc17_count", int'(bus.count), 16);
      drive(0, 0, 0, 1, 0, 0);
      tick();
      drive(1, 7, 33, 0, 0, 0);
      tick();
      chk("full_retire_count", int'(bus.count), 15);
      chk("full_retire_commit", int'(bus.commit_valid), 1);
      tick();
      chk("refill_count", int'(bus.count), 16);

      do_reset();
      for (int c = 0; c < 90; c++) begin
         cv = 0;
         ct = 0;
         if (mq.size() > 0) begin
            k = $urandom_range(0, mq.size() - 1);
            if (!mq[k].done) begin
               cv = 1;
               ct = 4'(mq[k].tag);
            end
         end
         drive($urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)), 6'($urandom_range(0, 63)), cv, ct, 0);
         tick();
         chk("wrap_count_le_16", int'(bus.count <= 16), 1);
      end
      for (int c = 0; c < 100 && mq.size() > 0; c++) begin
         cv = 0;
         ct = 0;
         foreach (mq[i]) if (!cv && !mq[i].done) begin
            cv = 1;
            ct = 4'(mq[i].tag);
         end
         drive(0, 0, 0, cv, ct, 0);
         tick();
      end
      chk("wrap_drained", mq.size(), 0);
      chk("wrap_retires_ge_40", int'(n_ret >= 40), 1);

      do_reset();
      for (int i = 0; i < 5; i++) begin
         drive(1, 5'(i + 1), 6'(i + 50), 0, 0, 0);
         tick();
      end
      drive(0, 0, 0, 1, 0, 0);
      tick();
      drive(0, 0, 0, 1, 1, 1);
      tick();
      chk("flush_count", int'(bus.count), 0);
      chk("flush_commit", int'(bus.commit_valid), 0);
      drive(0, 0, 0, 0, 0, 0);
      tick();
      chk("post_flush_commit", int'(bus.commit_valid), 0);
      chk("post_flush_tag", int'(bus.alloc_tag), 0);
      drive(1, 6, 44, 0, 0, 0);
      tick();
      drive(0, 0, 0, 1, 0, 0);
      tick();
      drive(0, 0, 0, 0, 0, 0);
      tick();
      chk("post_flush_phys", int'(bus.retire_phys_reg), 44);

      do_reset();
      drive(1, 5, 50, 0, 0, 0);
      tick();
      drive(1, 6, 51, 0, 0, 0);
      tick();
      drive(0, 0, 0, 1, 0, 0);
      tick();
      drive(0, 0, 0, 0, 0, 0);
      tick();
      chk("pre_async_commit", int'(bus.commit_valid), 1);
      #3;
      rst = 1'b1;
      #1;
      chk("async_commit", int'(bus.commit_valid), 0);
      chk("async_retire", int'(bus.retire_valid), 0);
      chk("async_phys", int'(bus.retire_phys_reg), 0);
      chk("async_count", int'(bus.count), 0);
      chk("async_ready", int'(bus.alloc_ready), 1);
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_clear();
      tick();
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/reorder_buffer.md
REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 Parameter DEPTH, default 16, number of in-flight entries; power of two.
REQ-002 Parameter TAG_W, default 4, equal to log2(DEPTH).
REQ-003 Parameter PHYS_W, default 6, physical register index width.
REQ-004 Ports: one clock; reset is asynchronous and active-high.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 reset  in  1  asynchronous, active-high; clears all state.
REQ-007 alloc_valid  in  1  renamed instruction presented for allocation.
REQ-008 alloc_rd  in  5  architectural destination register.
REQ-009 alloc_old_phys_rd  in  PHYS_W  previous mapping of alloc_rd, freed at retire.
REQ-010 alloc_ready  out  1  entry available.
REQ-011 alloc_tag  out  TAG_W  index the next accepted instruction receives.
REQ-012 complete_valid  in  1  execution writeback strobe.
REQ-013 complete_tag  in  TAG_W  entry that finished.
REQ-014 flush  in  1  discard all entries.
REQ-015 commit_valid  out  1  one instruction retired this cycle.
REQ-016 retire_valid  out  1  retired instruction frees a physical register.
REQ-017 retire_phys_reg  out  PHYS_W  register to return to the free list.
REQ-018 count  out  TAG_W+1  occupied entries.

Function
REQ-019 Circular buffer: head and tail pointers of TAG_W+1 bits, MSB as wrap bit; empty when pointers are equal, full when they differ only in the MSB.
REQ-020 alloc_ready = !full, combinational from current state; alloc_tag = tail[TAG_W-1:0].
REQ-021 Allocation fires when alloc_valid && alloc_ready at a rising edge: entry[tail] gets valid=1, done=0, rd, old_phys; tail increments with wrap.
REQ-022 Completion at an edge sets done of entry[complete_tag] only if that entry is valid before the edge; otherwise it is ignored.
REQ-023 Retire: at an edge where entry[head] is valid and done, entry clears and head increments; at most one retire per cycle.
REQ-024 commit_valid, retire_valid and retire_phys_reg are registered and assert in the cycle after the retiring edge, for exactly one cycle per retire.
REQ-025 retire_valid = commit_valid && (retired rd != 0); retire_phys_reg holds old_phys when retire_valid is high, else 0.
REQ-026 Minimum latency: completion at edge N, retire at edge N+1, commit_valid high after edge N+1.
REQ-027 Allocate and retire at the same edge are both honoured; count is unchanged.
REQ-028 When full, alloc_valid is not accepted even if a retire occurs at the same edge.
REQ-029 Completion of a tag being allocated at the same edge is ignored.
REQ-030 flush has priority over alloc, complete and retire: all valid bits clear, head=tail=0, and outputs are 0 after that edge.
REQ-031 count = tail - head, modulo 2^(TAG_W+1).

Reset
REQ-032 While reset is high: head=tail=0, all valid/done=0, commit_valid=retire_valid=0, retire_phys_reg=0, count=0, alloc_ready=1, alloc_tag=0.
REQ-033 Reset asserted mid-operation discards every in-flight entry immediately, without waiting for a clock edge.

Structure
REQ-034 Shared package holds ARCH_REG_W=5, PHYS_W=6, ROB_DEPTH and ROB_TAG_W, and the entry record (valid, done, rd, old_phys).
REQ-035 One sub-module, rob_ptr: a wrap-bit pointer counter with increment and clear, instantiated for head and tail.

Verification
REQ-036 Reset, then allocate 16 instructions (tags 0..15) -> alloc_ready=0 and count=16; 17th alloc_valid is not accepted.
REQ-037 Complete tag 3 only -> no commit; then complete tags 0,1,2 -> four commits on consecutive cycles in order 0,1,2,3.
REQ-038 Allocate rd=0 with old_phys=40, then complete -> commit_valid=1, retire_valid=0, retire_phys_reg=0.
REQ-039 Full buffer with head done: allocate and retire at the same edge -> alloc is not accepted; next cycle count=15 and alloc is accepted.
REQ-040 Pointer wrap: run 40 alloc/complete/retire cycles -> retire_phys_reg sequence matches allocation order across wrap; count never exceeds 16.
REQ-041 flush with 5 entries pending and a simultaneous complete -> count=0 and no commit on the following cycle; reset pulsed mid-stream clears outputs without a clock edge.
